// File: rtl/bcd_pkg.sv
// Shared types and helpers for the binary-to-BCD converter.
// Holds the digit type, the add-3 threshold, FSM states and a sizing helper.
package bcd_pkg;

    typedef logic [3:0] digit_t;

    localparam digit_t ADD3_THRESHOLD = 4'd5;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FIN
    } state_t;

    // Decimal digits needed for 2^width-1: floor(width*log10(2)) + 1.
    function automatic int unsigned digits_required(input int unsigned width);
        return (width * 30103) / 100000 + 1;
    endfunction

endpackage

// File: rtl/bin_to_bcd_conv_if.sv
// Request/result bundle for bin_to_bcd_conv.
// The master drives the request; the slave returns status and results.
interface bin_to_bcd_conv_if #(
    parameter int unsigned BIN_W  = 20,
    parameter int unsigned DIGITS = 7
);
    localparam int unsigned ND_W = $clog2(DIGITS + 1);

    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  signed_mode;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  neg;
    logic [ND_W-1:0]       ndigits;
    logic                  ovf;

    modport master (
        output start, bin, signed_mode,
        input  busy, done, bcd, neg, ndigits, ovf
    );

    modport slave (
        input  start, bin, signed_mode,
        output busy, done, bcd, neg, ndigits, ovf
    );

endinterface

// File: rtl/bcd_digit_cell.sv
// One double-dabble digit: add 3 when >= 5, shift one bit in, pass the top bit out.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  digit_t digit,
    input  logic   shift_in,
    output digit_t digit_next,
    output logic   carry
);

    digit_t adjusted;

    always_comb begin
        adjusted = digit;
        if (digit >= ADD3_THRESHOLD) begin
            adjusted = digit + 4'd3;
        end
    end

    assign digit_next = {adjusted[2:0], shift_in};
    assign carry      = adjusted[3];

endmodule

// File: rtl/bin_to_bcd_conv.sv
// Sequential double-dabble converter: one bit per cycle, signed-magnitude input,
// sticky overflow when the result needs more than DIGITS digits.
module bin_to_bcd_conv
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W     = 20,
    parameter int unsigned DIGITS    = 7,
    // Clear for instances that are intentionally narrower than BIN_W needs.
    parameter bit          SIZE_WARN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    bin_to_bcd_conv_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned ND_W  = $clog2(DIGITS + 1);

    if (SIZE_WARN && (DIGITS < digits_required(BIN_W))) begin : g_size_warn
        $warning("bin_to_bcd_conv: DIGITS=%0d is below the %0d digits BIN_W=%0d can need",
                 DIGITS, digits_required(BIN_W), BIN_W);
    end

    state_t             state;
    state_t             state_next;
    logic [BIN_W-1:0]   sreg;
    digit_t             dig      [DIGITS];
    digit_t             dig_next [DIGITS];
    logic [DIGITS:0]    chain;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_flag;
    logic               neg_flag;

    logic [4*DIGITS-1:0] dig_packed;
    logic [ND_W-1:0]     nd_calc;

    logic [4*DIGITS-1:0] bcd_r;
    logic                neg_r;
    logic                ovf_r;
    logic [ND_W-1:0]     nd_r;
    logic                done_r;

    assign chain[0] = sreg[BIN_W-1];

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit_cell u_cell (
            .digit      (dig[i]),
            .shift_in   (chain[i]),
            .digit_next (dig_next[i]),
            .carry      (chain[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1)) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        dig_packed = '0;
        nd_calc    = ND_W'(1);
        for (int unsigned i = 0; i < DIGITS; i++) begin
            dig_packed[4*i +: 4] = dig[i];
            if (dig[i] != '0) begin
                nd_calc = ND_W'(i + 1);
            end
        end
        if (ovf_flag) begin
            nd_calc = ND_W'(DIGITS);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg     <= '0;
            dig      <= '{default: '0};
            cnt      <= '0;
            ovf_flag <= 1'b0;
            neg_flag <= 1'b0;
            bcd_r    <= '0;
            neg_r    <= 1'b0;
            ovf_r    <= 1'b0;
            nd_r     <= '0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // Magnitude is kept as unsigned BIN_W bits so -2^(BIN_W-1) maps to itself.
                        sreg     <= (bus.signed_mode && bus.bin[BIN_W-1]) ? -bus.bin : bus.bin;
                        neg_flag <= bus.signed_mode & bus.bin[BIN_W-1];
                        dig      <= '{default: '0};
                        cnt      <= CNT_W'(BIN_W);
                        ovf_flag <= 1'b0;
                    end
                end
                SHIFT: begin
                    sreg <= sreg << 1;
                    dig  <= dig_next;
                    cnt  <= cnt - CNT_W'(1);
                    if (chain[DIGITS]) begin
                        ovf_flag <= 1'b1;
                    end
                end
                FIN: begin
                    bcd_r  <= dig_packed;
                    neg_r  <= neg_flag;
                    ovf_r  <= ovf_flag;
                    nd_r   <= nd_calc;
                    done_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state != IDLE);
    assign bus.done    = done_r;
    assign bus.bcd     = bcd_r;
    assign bus.neg     = neg_r;
    assign bus.ovf     = ovf_r;
    assign bus.ndigits = nd_r;

endmodule

// File: tb/tb_bin_to_bcd_conv.sv
// Scoreboard bench for bin_to_bcd_conv: a 20-bit/7-digit instance and a 10-bit/3-digit
// instance that overflows; monitors pop expected results on every done pulse.
module tb_bin_to_bcd_conv;

    typedef struct {
        logic [27:0] bcd;
        logic        neg;
        logic        ovf;
        logic [2:0]  nd;
        int unsigned cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned cyc = 0;
    int checks   = 0;
    int failures = 0;

    exp_t main_q[$];
    exp_t small_q[$];

    bin_to_bcd_conv_if #(.BIN_W(20), .DIGITS(7)) mb ();
    bin_to_bcd_conv_if #(.BIN_W(10), .DIGITS(3)) sb ();

    bin_to_bcd_conv #(.BIN_W(20), .DIGITS(7)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (mb)
    );

    bin_to_bcd_conv #(.BIN_W(10), .DIGITS(3), .SIZE_WARN(1'b0)) u_small (
        .clk (clk),
        .rst (rst),
        .bus (sb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin : mon_main
        exp_t e;
        if (!rst && mb.done) begin
            if (main_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL main_spurious_done actual=done required=no_done cyc=%0d", cyc);
            end else begin
                e = main_q.pop_front();
                check("main_bcd",        64'(mb.bcd),     64'(e.bcd));
                check("main_neg",        64'(mb.neg),     64'(e.neg));
                check("main_ovf",        64'(mb.ovf),     64'(e.ovf));
                check("main_ndigits",    64'(mb.ndigits), 64'(e.nd));
                check("main_done_cycle", 64'(cyc),        64'(e.cyc));
                check("main_busy_done",  64'(mb.busy),    64'd0);
            end
        end
    end

    always @(negedge clk) begin : mon_small
        exp_t e;
        if (!rst && sb.done) begin
            if (small_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL small_spurious_done actual=done required=no_done cyc=%0d", cyc);
            end else begin
                e = small_q.pop_front();
                check("small_bcd",        64'(sb.bcd),     64'(e.bcd));
                check("small_neg",        64'(sb.neg),     64'(e.neg));
                check("small_ovf",        64'(sb.ovf),     64'(e.ovf));
                check("small_ndigits",    64'(sb.ndigits), 64'(e.nd));
                check("small_done_cycle", 64'(cyc),        64'(e.cyc));
            end
        end
    end

    task automatic drain(input string name);
        int unsigned t = 0;
        while ((main_q.size() != 0 || small_q.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (main_q.size() != 0 || small_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=pending required=drained", name);
            main_q.delete();
            small_q.delete();
        end
    endtask

    task automatic wait_idle_main();
        int unsigned t = 0;
        @(negedge clk);
        while (mb.busy && t < 100) begin
            @(negedge clk);
            t++;
        end
    endtask

    // pester=1 pulses start with junk operands while the conversion is in flight.
    task automatic convert(input logic [19:0] b, input logic sm, input logic [27:0] eb,
                           input logic en, input logic eo, input logic [2:0] endg,
                           input bit pester);
        exp_t e;
        wait_idle_main();
        mb.start = 1'b1;
        mb.bin = b;
        mb.signed_mode = sm;
        @(posedge clk);
        #1;
        e.bcd = eb; e.neg = en; e.ovf = eo; e.nd = endg; e.cyc = cyc + 21;
        main_q.push_back(e);
        check("main_busy_accept", 64'(mb.busy), 64'd1);
        @(negedge clk);
        mb.start = 1'b0;
        mb.bin = ~b;
        mb.signed_mode = ~sm;
        if (pester) begin
            for (int i = 0; i < 19; i++) begin
                mb.start = (i % 4 == 1);
                mb.bin = 20'd5;
                @(negedge clk);
            end
            mb.start = 1'b0;
        end
        drain("main_convert");
        repeat (2) @(negedge clk);
        check("main_hold_bcd", 64'(mb.bcd), 64'(eb));
    endtask

    task automatic convert_small(input logic [9:0] b, input logic sm, input logic [11:0] eb,
                                 input logic en, input logic eo, input logic [1:0] endg);
        exp_t e;
        int unsigned t = 0;
        @(negedge clk);
        while (sb.busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        sb.start = 1'b1;
        sb.bin = b;
        sb.signed_mode = sm;
        @(posedge clk);
        #1;
        e.bcd = 28'(eb); e.neg = en; e.ovf = eo; e.nd = 3'(endg); e.cyc = cyc + 11;
        small_q.push_back(e);
        @(negedge clk);
        sb.start = 1'b0;
        sb.bin = ~b;
        drain("small_convert");
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [19:0] b2b_bin [3];
        logic [27:0] b2b_bcd [3];
        logic [2:0]  b2b_nd  [3];
        exp_t e;

        b2b_bin = '{20'd42, 20'd999999, 20'd1000000};
        b2b_bcd = '{28'h0000042, 28'h0999999, 28'h1000000};
        b2b_nd  = '{3'd2, 3'd6, 3'd7};

        mb.start = 1'b0; mb.bin = '0; mb.signed_mode = 1'b0;
        sb.start = 1'b0; sb.bin = '0; sb.signed_mode = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy",    64'(mb.busy),    64'd0);
        check("reset_done",    64'(mb.done),    64'd0);
        check("reset_bcd",     64'(mb.bcd),     64'd0);
        check("reset_neg",     64'(mb.neg),     64'd0);
        check("reset_ovf",     64'(mb.ovf),     64'd0);
        check("reset_ndigits", 64'(mb.ndigits), 64'd0);
        rst = 1'b0;

        convert(20'd0,       1'b0, 28'h0000000, 1'b0, 1'b0, 3'd1, 1'b0);
        convert(20'd1048575, 1'b0, 28'h1048575, 1'b0, 1'b0, 3'd7, 1'b0);
        convert(20'hFFFFF,   1'b1, 28'h0000001, 1'b1, 1'b0, 3'd1, 1'b0);
        convert(20'h80000,   1'b1, 28'h0524288, 1'b1, 1'b0, 3'd6, 1'b0);
        convert(20'h80000,   1'b0, 28'h0524288, 1'b0, 1'b0, 3'd6, 1'b0);
        convert(20'h7FFFF,   1'b1, 28'h0524287, 1'b0, 1'b0, 3'd6, 1'b0);
        convert(20'hFFF9C,   1'b1, 28'h0000100, 1'b1, 1'b0, 3'd3, 1'b0);
        convert(20'd12345,   1'b0, 28'h0012345, 1'b0, 1'b0, 3'd5, 1'b0);
        convert(20'd9,       1'b0, 28'h0000009, 1'b0, 1'b0, 3'd1, 1'b0);
        convert(20'd10,      1'b0, 28'h0000010, 1'b0, 1'b0, 3'd2, 1'b0);
        convert(20'd777777,  1'b0, 28'h0777777, 1'b0, 1'b0, 3'd6, 1'b1);
        repeat (30) @(negedge clk);

        // start held high: a new operand is presented in each done cycle
        wait_idle_main();
        mb.start = 1'b1;
        mb.signed_mode = 1'b0;
        mb.bin = b2b_bin[0];
        for (int j = 0; j < 3; j++) begin
            @(posedge clk);
            #1;
            e.bcd = b2b_bcd[j]; e.neg = 1'b0; e.ovf = 1'b0; e.nd = b2b_nd[j]; e.cyc = cyc + 21;
            main_q.push_back(e);
            @(negedge clk);
            mb.bin = 20'hABCDE;
            repeat (21) @(negedge clk);
            if (j < 2) mb.bin = b2b_bin[j + 1];
            else mb.start = 1'b0;
        end
        drain("back_to_back");

        // reset after ten shifts, with start also high to test reset priority
        wait_idle_main();
        mb.start = 1'b1;
        mb.bin = 20'd555;
        @(posedge clk);
        @(negedge clk);
        mb.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        mb.start = 1'b1;
        @(negedge clk);
        check("abort_busy",    64'(mb.busy),    64'd0);
        check("abort_done",    64'(mb.done),    64'd0);
        check("abort_bcd",     64'(mb.bcd),     64'd0);
        check("abort_neg",     64'(mb.neg),     64'd0);
        check("abort_ovf",     64'(mb.ovf),     64'd0);
        check("abort_ndigits", 64'(mb.ndigits), 64'd0);
        rst = 1'b0;
        mb.start = 1'b0;
        repeat (30) @(negedge clk);
        check("abort_idle_busy", 64'(mb.busy), 64'd0);
        convert(20'd321, 1'b0, 28'h0000321, 1'b0, 1'b0, 3'd3, 1'b0);

        convert_small(10'd1000, 1'b0, 12'h000, 1'b0, 1'b1, 2'd3);
        convert_small(10'd999,  1'b0, 12'h999, 1'b0, 1'b0, 2'd3);
        convert_small(10'd1023, 1'b0, 12'h023, 1'b0, 1'b1, 2'd3);
        convert_small(10'h200,  1'b1, 12'h512, 1'b1, 1'b0, 2'd3);
        convert_small(10'd5,    1'b0, 12'h005, 1'b0, 1'b0, 2'd1);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_conv.md
BIN_TO_BCD_CONV -- requirements
Module: bin_to_bcd_conv

Interface
REQ-001 Parameter BIN_W, default 20: width of the binary input, at least 2.
REQ-002 Parameter DIGITS, default 7: number of BCD output digits, at least 1.
REQ-003 clk  input  1: single clock; all logic on its rising edge.
REQ-004 rst  input  1: reset, synchronous, active-high.
REQ-005 start  input  1: conversion request; sampled only when the FSM is in IDLE.
REQ-006 bin  input  BIN_W: operand; captured on the accepting edge and ignored otherwise.
REQ-007 signed_mode  input  1: 1 = bin is two's complement; captured together with bin.
REQ-008 busy  output  1: high in SHIFT and FIN; low in IDLE.
REQ-009 done  output  1: one-cycle pulse when results update.
REQ-010 bcd  output  4*DIGITS: packed digits; digit 0 in [3:0].
REQ-011 neg  output  1: result is negative; set only when signed_mode=1 and bin MSB=1.
REQ-012 ndigits  output  clog2(DIGITS+1): count of significant digits; value 0 gives 1.
REQ-013 ovf  output  1: magnitude does not fit in DIGITS digits.

Function
REQ-014 The FSM SHALL use three states: IDLE, SHIFT and FIN.
REQ-015 Transitions: IDLE->SHIFT on start=1; SHIFT->FIN after BIN_W shifts; FIN->IDLE unconditionally.
REQ-016 On the accepting edge the block SHALL load the magnitude into the shift register: -bin if signed_mode=1 and bin[BIN_W-1]=1, else bin.
REQ-017 On the accepting edge the block SHALL clear all digit registers and set the shift counter to BIN_W.
REQ-018 The magnitude SHALL be treated as unsigned BIN_W bits, so the most negative input yields 2^(BIN_W-1) with no error.
REQ-019 Each SHIFT cycle: every digit >=5 is incremented by 3, then the chain {digits, shift register} shifts left one bit, the shift-register MSB entering digit 0.
REQ-020 During any shift, a 1 leaving the top digit SHALL set a sticky internal overflow flag, cleared on accept.
REQ-021 On the FIN edge the block SHALL register bcd, neg, ovf and ndigits, and set done=1 for exactly the following cycle.
REQ-022 ndigits SHALL equal the index of the highest nonzero digit plus 1, with minimum 1.
REQ-023 On ovf=1, bcd SHALL hold the low DIGITS digits of the truncated result and ndigits SHALL equal DIGITS.
REQ-024 Latency: done SHALL be high in the cycle after edge k+BIN_W+1, where k is the accepting edge.
REQ-025 start SHALL be ignored while busy=1; no queueing.
REQ-026 start=1 in the cycle where done=1 SHALL be accepted, giving a back-to-back period of BIN_W+2 cycles.
REQ-027 bcd, neg, ovf and ndigits SHALL hold their values until the next FIN edge.
REQ-028 Changes on bin or signed_mode after acceptance SHALL have no effect on the result in flight.

Reset
REQ-029 rst=1 SHALL force IDLE and clear all outputs: busy=0, done=0, bcd=0, neg=0, ovf=0, ndigits=0.
REQ-030 rst=1 SHALL clear the shift register, digit registers, counter and overflow flag.
REQ-031 rst=1 during SHIFT or FIN SHALL abort the conversion with no done pulse.
REQ-032 rst has priority over start in the same cycle.

Structure
REQ-033 Shared package bcd_pkg SHALL hold the 4-bit digit type, the add-3 threshold constant (5) and a digits-required function for BIN_W.
REQ-034 One sub-module, bcd_digit_cell, SHALL implement one digit: conditional add-3, shift-in bit, carry-out; DIGITS instances SHALL be generated.
REQ-035 An elaboration-time check SHALL warn when DIGITS is smaller than the digits-required function for BIN_W.

Verification (BIN_W=20, DIGITS=7 unless noted)
REQ-036 bin=0, signed_mode=0 -> bcd=0x0000000, ndigits=1, neg=0, ovf=0; done high in the cycle after edge k+21.
REQ-037 bin=1048575, signed_mode=0 -> bcd=0x1048575, ndigits=7, ovf=0.
REQ-038 bin=0xFFFFF, signed_mode=1 -> bcd=0x0000001, neg=1, ndigits=1; bin=0x80000, signed_mode=1 -> bcd=0x0524288, neg=1.
REQ-039 Instance DIGITS=3, bin=1000 -> ovf=1, bcd=0x000, ndigits=3; the next conversion, bin=999, -> ovf=0, bcd=0x999.
REQ-040 start held high continuously -> accepts every 22 cycles; start pulses while busy ignored; rst at shift 10 -> no done, outputs zero, the next start converts correctly.
